// File: rtl/operand_load_stage.sv
// ---------------------------------------------------------------------------
// operand_load_stage
//
// Decodes a 4-bit operand load select code, assembles the matching immediate
// from the instruction word and registers an (operandA, operandB) pair for
// the execute stage behind a single-entry valid/ready handshake.
//
// Ports
//   clk          rising-edge clock for all state
//   reset        synchronous, active-high reset
//   loadSel      operand load select code (13..15 are illegal)
//   instruction  instruction word supplying the immediate fields
//   nextPc       address of the following instruction
//   rfA, rfB     register file read data, ports A and B
//   inValid      input bundle valid
//   inReady      stage accepts the bundle this cycle (combinational)
//   operandA/B   registered operand pair
//   outValid     operandA/operandB hold a valid pair
//   outReady     consumer takes the pair this cycle
//   illegalSel   sticky: an accepted loadSel was 13..15
// ---------------------------------------------------------------------------
module operand_load_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  loadSel,
  input  logic [31:0] instruction,
  input  logic [31:0] nextPc,
  input  logic [31:0] rfA,
  input  logic [31:0] rfB,
  input  logic        inValid,
  output logic        inReady,
  output logic [31:0] operandA,
  output logic [31:0] operandB,
  output logic        outValid,
  input  logic        outReady,
  output logic        illegalSel
);

  typedef enum logic [3:0] {
    SEL_NO_OP         = 4'd0,
    SEL_NEXTPC_IMM24  = 4'd1,
    SEL_RFA_IMM19     = 4'd2,
    SEL_NEXTPC_IMM21B = 4'd3,
    SEL_NEXTPC_IMM21C = 4'd4,
    SEL_NULL_COMBO    = 4'd5,
    SEL_NULL_IMM21B   = 4'd6,
    SEL_NULL_RFB      = 4'd7,
    SEL_RFA_IMM16A    = 4'd8,
    SEL_RFA_IMM16B    = 4'd9,
    SEL_RFA_IMM21A    = 4'd10,
    SEL_RFA_IMM5      = 4'd11,
    SEL_RFA_RFB       = 4'd12
  } load_sel_e;

  // Immediate fields. Split fields are concatenated first and the sign is
  // taken from the top bit of the assembled field.
  logic [31:0] imm24, imm19, imm21b, imm21c, imm16a, imm16b, imm21a, imm5, combo;

  assign imm24  = {{6{instruction[23]}}, instruction[23:0], 2'b00};
  assign imm19  = {{11{instruction[18]}}, instruction[18:0], 2'b00};
  assign imm21b = {{11{instruction[20]}}, instruction[20:0]};
  assign imm21c = {{11{instruction[25]}}, instruction[25:21], instruction[15:0]};
  assign imm16a = {{16{instruction[15]}}, instruction[15:0]};
  assign imm16b = {{16{instruction[25]}}, instruction[25:21], instruction[10:0]};
  assign imm21a = {{11{instruction[20]}}, instruction[20:0]};
  assign imm5   = {27'd0, instruction[4:0]};
  assign combo  = {instruction[15:0], 16'h0000};

  logic [31:0] operand_a_q, operand_a_d;
  logic [31:0] operand_b_q, operand_b_d;
  logic        out_valid_q, out_valid_d;
  logic        illegal_sel_q, illegal_sel_d;

  logic [31:0] new_a, new_b;
  logic        sel_illegal;
  logic        accept;

  // Operand source decode.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned and infers a latch.
    new_a       = '0;
    new_b       = '0;
    sel_illegal = 1'b0;
    case (load_sel_e'(loadSel))
      SEL_NO_OP:         ;
      SEL_NEXTPC_IMM24:  begin new_a = nextPc; new_b = imm24;  end
      SEL_RFA_IMM19:     begin new_a = rfA;    new_b = imm19;  end
      SEL_NEXTPC_IMM21B: begin new_a = nextPc; new_b = imm21b; end
      SEL_NEXTPC_IMM21C: begin new_a = nextPc; new_b = imm21c; end
      SEL_NULL_COMBO:    new_b = combo;
      SEL_NULL_IMM21B:   new_b = imm21b;
      SEL_NULL_RFB:      new_b = rfB;
      SEL_RFA_IMM16A:    begin new_a = rfA;    new_b = imm16a; end
      SEL_RFA_IMM16B:    begin new_a = rfA;    new_b = imm16b; end
      SEL_RFA_IMM21A:    begin new_a = rfA;    new_b = imm21a; end
      SEL_RFA_IMM5:      begin new_a = rfA;    new_b = imm5;   end
      SEL_RFA_RFB:       begin new_a = rfA;    new_b = rfB;    end
      default:           sel_illegal = 1'b1;  // 13..15 load zeros
    endcase
  end

  // A drained or empty slot may refill in the same cycle, so a streaming
  // consumer sees no bubble.
  assign inReady = !out_valid_q || outReady;
  assign accept  = inValid && inReady;

  always_comb begin
    operand_a_d   = operand_a_q;
    operand_b_d   = operand_b_q;
    out_valid_d   = out_valid_q;
    illegal_sel_d = illegal_sel_q;
    if (accept) begin
      operand_a_d   = new_a;
      operand_b_d   = new_b;
      out_valid_d   = 1'b1;
      illegal_sel_d = illegal_sel_q || sel_illegal;
    end else if (outReady) begin
      // Pair consumed with nothing behind it: operands keep their old value.
      out_valid_d = 1'b0;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      operand_a_q   <= '0;
      operand_b_q   <= '0;
      out_valid_q   <= 1'b0;
      illegal_sel_q <= 1'b0;
    end else begin
      operand_a_q   <= operand_a_d;
      operand_b_q   <= operand_b_d;
      out_valid_q   <= out_valid_d;
      illegal_sel_q <= illegal_sel_d;
    end
  end

  assign operandA   = operand_a_q;
  assign operandB   = operand_b_q;
  assign outValid   = out_valid_q;
  assign illegalSel = illegal_sel_q;

endmodule

// File: tb/tb_operand_load_stage.sv
// ---------------------------------------------------------------------------
// tb_operand_load_stage
//
// Scoreboard bench: the stimulus side pushes the reference pair for every
// accepted bundle; a negedge monitor compares the DUT's presented pair, the
// handshake and the sticky flag against the scoreboard contents.
// ---------------------------------------------------------------------------
module tb_operand_load_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  loadSel;
  logic [31:0] instruction, nextPc, rfA, rfB;
  logic        inValid, outReady;
  logic        inReady, outValid, illegalSel;
  logic [31:0] operandA, operandB;

  int tests = 0;
  int fails = 0;

  logic [63:0] sb_q[$];          // pairs the DUT currently owes, {a, b}
  logic [63:0] last_pair = '0;   // operands expected while no pair is valid
  logic        exp_illegal = 1'b0;
  bit          mon_en = 1'b0;

  operand_load_stage dut (
    .clk(clk), .reset(reset), .loadSel(loadSel), .instruction(instruction),
    .nextPc(nextPc), .rfA(rfA), .rfB(rfB), .inValid(inValid),
    .inReady(inReady), .operandA(operandA), .operandB(operandB),
    .outValid(outValid), .outReady(outReady), .illegalSel(illegalSel)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Sign-extend the low n bits of v by arithmetic: a set sign bit means the
  // field's value is v - 2^n.
  function automatic logic [31:0] sext(input logic [31:0] v, input int n);
    if (v[n-1]) return v - (32'd1 << n);
    return v;
  endfunction

  function automatic logic [63:0] model(input logic [3:0] sel, input logic [31:0] ins,
                                        input logic [31:0] npc, input logic [31:0] ra,
                                        input logic [31:0] rb);
    logic [31:0] a, b;
    logic [31:0] f24, f19, f21, f16, hi5, lo16, lo11;
    f24  = ins & 32'h00FF_FFFF;
    f19  = ins & 32'h0007_FFFF;
    f21  = ins & 32'h001F_FFFF;
    f16  = ins & 32'h0000_FFFF;
    lo16 = f16;
    lo11 = ins & 32'h0000_07FF;
    hi5  = (ins >> 21) & 32'h1F;
    a = 32'h0;
    b = 32'h0;
    case (sel)
      4'd1:  begin a = npc; b = sext(f24, 24) * 32'd4; end
      4'd2:  begin a = ra;  b = sext(f19, 19) * 32'd4; end
      4'd3:  begin a = npc; b = sext(f21, 21); end
      4'd4:  begin a = npc; b = sext(hi5 * 32'h1_0000 + lo16, 21); end
      4'd5:  b = lo16 * 32'h1_0000;
      4'd6:  b = sext(f21, 21);
      4'd7:  b = rb;
      4'd8:  begin a = ra;  b = sext(f16, 16); end
      4'd9:  begin a = ra;  b = sext(hi5 * 32'd2048 + lo11, 16); end
      4'd10: begin a = ra;  b = sext(f21, 21); end
      4'd11: begin a = ra;  b = ins & 32'h1F; end
      4'd12: begin a = ra;  b = rb; end
      default: ;
    endcase
    return {a, b};
  endfunction

  // Inputs currently driven take effect at the next rising edge; the model is
  // updated at that edge, and the task returns 1 ns after it.
  task automatic tick();
    bit          acc;
    logic [63:0] exp;
    acc = inValid && (sb_q.size() == 0 || outReady);
    exp = model(loadSel, instruction, nextPc, rfA, rfB);
    @(posedge clk);
    if (reset) begin
      sb_q.delete();
      last_pair   = '0;
      exp_illegal = 1'b0;
    end else if (acc) begin
      sb_q.push_back(exp);
      if (loadSel >= 4'd13) exp_illegal = 1'b1;
    end
    #1;
  endtask

  // Monitor: mid-cycle, with inputs stable.
  always @(negedge clk) begin
    if (mon_en) begin
      check("in_ready", {31'd0, inReady}, {31'd0, (sb_q.size() == 0) || outReady});
      check("out_valid", {31'd0, outValid}, {31'd0, sb_q.size() != 0});
      check("illegal_sel", {31'd0, illegalSel}, {31'd0, exp_illegal});
      if (sb_q.size() != 0) begin
        check("operand_a", operandA, sb_q[0][63:32]);
        check("operand_b", operandB, sb_q[0][31:0]);
        if (outReady) last_pair = sb_q.pop_front();
      end else begin
        check("hold_a", operandA, last_pair[63:32]);
        check("hold_b", operandB, last_pair[31:0]);
      end
    end
  end

  task automatic bundle(input logic [3:0] sel, input logic [31:0] ins,
                        input logic [31:0] npc, input logic [31:0] ra, input logic [31:0] rb);
    loadSel = sel; instruction = ins; nextPc = npc; rfA = ra; rfB = rb;
  endtask

  task automatic do_reset();
    reset = 1'b1; inValid = 1'b0; outReady = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bundle(4'd0, '0, '0, '0, '0);
    do_reset();
    mon_en = 1'b1;
    check("reset_a", operandA, 32'h0);
    check("reset_b", operandB, 32'h0);
    check("reset_valid", {31'd0, outValid}, 32'h0);

    // IMM24 with nextPc.
    bundle(4'd1, 32'h00FF_FFFF, 32'h1000, 32'h0, 32'h0);
    inValid = 1'b1; outReady = 1'b1;
    tick();
    check("imm24_a", operandA, 32'h1000);
    check("imm24_b", operandB, 32'hFFFF_FFFC);

    // IMM16B, sign taken from instr[25].
    bundle(4'd9, 32'h0200_0005, 32'h0, 32'h20, 32'h0);
    tick();
    check("imm16b_a", operandA, 32'h20);
    check("imm16b_b", operandB, 32'hFFFF_8005);

    // COMBO.
    bundle(4'd5, 32'h0000_ABCD, 32'h0, 32'h55, 32'h66);
    tick();
    check("combo_a", operandA, 32'h0);
    check("combo_b", operandB, 32'hABCD_0000);

    // Backpressure: stall three cycles with a new bundle waiting.
    bundle(4'd12, 32'h0, 32'h0, 32'h1, 32'h2);
    tick();
    bundle(4'd12, 32'h0, 32'h0, 32'h3, 32'h4);
    outReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_a", operandA, 32'h1);
      check("stall_b", operandB, 32'h2);
      check("stall_ready", {31'd0, inReady}, 32'h0);
    end
    outReady = 1'b1;
    tick();
    check("refill_a", operandA, 32'h3);
    check("refill_b", operandB, 32'h4);
    check("refill_valid", {31'd0, outValid}, 32'h1);
    inValid = 1'b0;
    tick();
    check("drain_valid", {31'd0, outValid}, 32'h0);

    // Illegal code is sticky until reset.
    bundle(4'd14, 32'hFFFF_FFFF, 32'h1234, 32'h5678, 32'h9ABC);
    inValid = 1'b1;
    tick();
    check("illegal_a", operandA, 32'h0);
    check("illegal_b", operandB, 32'h0);
    check("illegal_valid", {31'd0, outValid}, 32'h1);
    check("illegal_set", {31'd0, illegalSel}, 32'h1);
    inValid = 1'b0;
    repeat (10) tick();
    check("illegal_sticky", {31'd0, illegalSel}, 32'h1);
    do_reset();
    check("illegal_cleared", {31'd0, illegalSel}, 32'h0);

    // Reset during a stall with a simultaneous accept drops everything.
    bundle(4'd12, 32'h0, 32'h0, 32'hA, 32'hB);
    inValid = 1'b1; outReady = 1'b1;
    tick();
    outReady = 1'b0;
    tick();
    reset = 1'b1; outReady = 1'b1;
    bundle(4'd12, 32'h0, 32'h0, 32'hC, 32'hD);
    tick();
    reset = 1'b0; inValid = 1'b0;
    check("rst_drop_valid", {31'd0, outValid}, 32'h0);
    check("rst_drop_a", operandA, 32'h0);
    check("rst_drop_b", operandB, 32'h0);

    // Randomized traffic, including all codes and occasional resets.
    for (int i = 0; i < 600; i++) begin
      bundle(4'($urandom_range(0, 15)), $urandom, $urandom, $urandom, $urandom);
      inValid  = ($urandom_range(0, 9) < 7);
      outReady = ($urandom_range(0, 9) < 6);
      reset    = ($urandom_range(0, 99) < 2);
      tick();
    end
    reset = 1'b0; inValid = 1'b0; outReady = 1'b1;
    repeat (3) tick();
    check("sb_empty", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/operand_load_stage.md
OPERAND_LOAD_STAGE -- requirements
Module: operand_load_stage

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 loadSel  input  4  operand load select code, encoding per REQ-014.
REQ-005 instruction  input  32  instruction word that supplies the immediate fields.
REQ-006 nextPc  input  32  address of the following instruction.
REQ-007 rfA  input  32  register file read port A data.
REQ-008 rfB  input  32  register file read port B data.
REQ-009 inValid  input  1  the input bundle is valid this cycle.
REQ-010 inReady  output  1  the stage accepts the input bundle this cycle.
REQ-011 operandA, operandB  output  32 each  registered operands for the execute stage.
REQ-012 outValid  output  1  operandA and operandB hold a valid pair; outReady  input  1  the consumer takes the pair this cycle.
REQ-013 illegalSel  output  1  sticky flag: an accepted loadSel was in the range 13..15.

Function
REQ-014 loadSel encoding: 0 NO_OP, 1 NEXTPC_IMM24, 2 RFA_IMM19, 3 NEXTPC_IMM21B, 4 NEXTPC_IMM21C, 5 NULL_COMBO, 6 NULL_IMM21B, 7 NULL_RFB, 8 RFA_IMM16A, 9 RFA_IMM16B, 10 RFA_IMM21A, 11 RFA_IMM5, 12 RFA_RFB; 13..15 illegal.
REQ-015 Immediate fields, all extended to 32 bits:
- IMM24 = sext(instr[23:0]) << 2
- IMM19 = sext(instr[18:0]) << 2
- IMM21B = sext(instr[20:0])
- IMM21C = sext({instr[25:21], instr[15:0]})
- IMM16A = sext(instr[15:0])
- IMM16B = sext({instr[25:21], instr[10:0]})
- IMM21A = sext(instr[20:0])
- IMM5 = zext(instr[4:0])
- COMBO = {instr[15:0], 16'h0000}
REQ-016 Operand source selection: the prefix names the source for operandA (NEXTPC = nextPc, RFA = rfA, NULL = 32'h0) and the suffix names the source for operandB (RFB = rfB, otherwise the immediate from REQ-015).
REQ-017 NO_OP and illegal codes SHALL load operandA = 0 and operandB = 0.
REQ-018 inReady SHALL equal !outValid || outReady, computed combinationally with no registered delay.
REQ-019 Accept condition is inValid && inReady; on accept, operandA and operandB SHALL update on the next rising edge and outValid SHALL be 1 (latency 1 cycle).
REQ-020 When outValid && !outReady, operandA, operandB and outValid SHALL hold their values.
REQ-021 When outReady is high and there is no accept in the same cycle, outValid SHALL clear on the next edge and the operands SHALL hold their last values.
REQ-022 When the consumer drains and the stage accepts in the same cycle, the new pair SHALL load, outValid SHALL stay 1, and there SHALL be no bubble.
REQ-023 NO_OP bundles are accepted like any other bundle and produce outValid = 1 with zero operands; the stage does not filter them.
REQ-024 illegalSel SHALL set on the edge after an accepted illegal code and hold until reset.
REQ-025 Inputs presented while inValid is low, or while the bundle is not accepted, SHALL have no effect on state.
REQ-026 All sign extension SHALL replicate the top bit of the assembled field; shifts SHALL discard the bits shifted out above bit 31.

Reset
REQ-027 While reset is high at a rising edge, operandA = 0, operandB = 0, outValid = 0 and illegalSel = 0 SHALL load, overriding any accept.
REQ-028 During reset, inReady SHALL follow REQ-018 using the pre-reset outValid; bundles accepted in that cycle are discarded.
REQ-029 Reset asserted while a pair is stalled (outValid = 1, outReady = 0) SHALL drop that pair.

Verification
REQ-030 loadSel = 1, instr[23:0] = 24'hFFFFFF, nextPc = 32'h1000, inValid = 1, outReady = 1 -> one cycle later operandA = 32'h1000, operandB = 32'hFFFFFFFC, outValid = 1.
REQ-031 loadSel = 9, instr[25:21] = 5'b10000, instr[10:0] = 11'h005, rfA = 32'h20 -> operandA = 32'h20, operandB = 32'hFFFF8005.
REQ-032 Backpressure: accept loadSel = 12 (rfA = 1, rfB = 2), hold outReady = 0 for 3 cycles with a new bundle offered -> inReady = 0 and operands stay 1/2 throughout; when outReady rises, the new bundle loads the next cycle with no bubble.
REQ-033 loadSel = 14 accepted -> operands 0/0, outValid = 1, illegalSel = 1 and still 1 ten cycles later; reset -> illegalSel = 0.
REQ-034 loadSel = 5, instr[15:0] = 16'hABCD -> operandA = 0, operandB = 32'hABCD0000.
REQ-035 Reset asserted in the same cycle as an accept with outValid = 1 -> next cycle outValid = 0 and operandA = operandB = 0.
